// File: rtl/simplerisc_pkg.sv
// Shared definitions for the simplerisc core: PC width, default reset PC and
// the fetch-sequencer state encoding.
package simplerisc_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] FS_BOOT  = 2'd0;
  localparam logic [1:0] FS_RUN   = 2'd1;
  localparam logic [1:0] FS_DRAIN = 2'd2;
  localparam logic [1:0] FS_HALT  = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT  = FS_BOOT,
    ST_RUN   = FS_RUN,
    ST_DRAIN = FS_DRAIN,
    ST_HALT  = FS_HALT
  } fs_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; it sticks at
// all-ones rather than wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter owner: picks the next fetch PC, applies load-use stalls,
// squashes wrong-path work on redirects and drains the pipe on hlt.
module fetch_sequencer
  import simplerisc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] PC_STEP      = 32'd1,
  parameter int              DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            ret_i,
  input  logic [PC_W-1:0] ra_i,
  input  logic            halt_i,
  output logic [PC_W-1:0] pc_o,
  output logic            pc_en_o,
  output logic            if_id_en_o,
  output logic            if_id_flush_o,
  output logic            id_ex_flush_o,
  output logic            halted_o,
  output logic [15:0]     redirect_cnt_o
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  if (DRAIN_CYCLES < 1) begin : g_bad_drain
    $error("fetch_sequencer: DRAIN_CYCLES must be at least 1");
  end

  fs_state_t       state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [DW-1:0]   drain_reg, drain_next;
  logic            halted_reg, halted_next;
  logic            redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_BOOT;
      pc_reg     <= RESET_PC;
      drain_reg  <= '0;
      halted_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      drain_reg  <= drain_next;
      halted_reg <= halted_next;
    end
  end

  // Defaults are the "frozen and flushing" outputs shared by BOOT, DRAIN and HALT.
  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    drain_next    = drain_reg;
    redirect      = 1'b0;
    pc_en_o       = 1'b0;
    if_id_en_o    = 1'b0;
    if_id_flush_o = 1'b1;
    id_ex_flush_o = 1'b1;
    case (state_reg)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (halt_i) begin
          drain_next = DW'(DRAIN_CYCLES - 1);
          state_next = ST_DRAIN;
        end else if (br_taken_i || ret_i) begin
          redirect   = 1'b1;
          pc_next    = br_taken_i ? br_target_i : ra_i;
          pc_en_o    = 1'b1;
          if_id_en_o = 1'b1;
        end else if (stall_i) begin
          if_id_flush_o = 1'b0;
        end else begin
          pc_next       = pc_reg + PC_STEP;
          pc_en_o       = 1'b1;
          if_id_en_o    = 1'b1;
          if_id_flush_o = 1'b0;
          id_ex_flush_o = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_reg == '0) begin
          state_next = ST_HALT;
        end else begin
          drain_next = drain_reg - DW'(1);
        end
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_BOOT;
    endcase
  end

  assign halted_next = (state_next == ST_HALT);

  sat_counter #(.WIDTH(16)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (redirect),
    .count (redirect_cnt_o)
  );

  assign pc_o     = pc_reg;
  assign halted_o = halted_reg;

endmodule
